adc_sampler: RTL and testbench

Parametrised multi-channel ADC capture block and the successor to the two-channel register stage at the sensor front end. It samples NUM_CH parallel ADC words at a programmable rate and box-car averages 2^AVG_LOG2 samples per channel. Each averaged frame is emitted as a channel-tagged stream over a valid/ready handshake to the UART/core logic. Frames that arrive while the previous one is still draining are dropped and flagged with a sticky overrun.

---
 rtl/adc_sampler.sv | 133 +++++++++++++
 tb/tb_adc_sampler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sampler.sv
// adc_sampler: multi-channel ADC capture with a programmable sample rate,
// 2^AVG_LOG2 box-car averaging and a channel-tagged valid/ready output stream.
module adc_sampler #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DIV_W    = 16,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         sample_div,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int unsigned ACC_W     = DATA_W + AVG_LOG2;
  localparam int unsigned SC_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned LAST_SAMP = (1 << AVG_LOG2) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [SC_W-1:0]    samp_cnt;
  logic [ACC_W-1:0]   acc       [NUM_CH];
  logic [DATA_W-1:0]  frame_buf [NUM_CH];

  logic               tick_c;
  logic               frame_done_c;
  logic               last_ch_c;
  logic [CH_W-1:0]    next_ch_c;
  logic [ACC_W-1:0]   sum_c     [NUM_CH];
  logic [DATA_W-1:0]  avg_c     [NUM_CH];

  assign tick_c       = enable && (div_cnt == sample_div);
  assign frame_done_c = tick_c && (samp_cnt == SC_W'(LAST_SAMP));
  assign last_ch_c    = (out_ch == CH_W'(NUM_CH - 1));
  assign next_ch_c    = out_ch + CH_W'(1);

  // Running sum including the sample on the current tick, and its truncated mean
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum_c[k] = acc[k] + ACC_W'(ch_data[k*DATA_W +: DATA_W]);
      avg_c[k] = DATA_W'(sum_c[k] >> AVG_LOG2);
    end
  end

  // Sample-rate prescaler; sample_div compared live every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!enable || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Accumulators; a disabled or completed frame restarts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (!enable) begin
      samp_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else if (tick_c) begin
      if (frame_done_c) begin
        samp_cnt <= '0;
        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      end else begin
        samp_cnt <= samp_cnt + SC_W'(1);
        for (int k = 0; k < NUM_CH; k++) acc[k] <= sum_c[k];
      end
    end
  end

  // Output FSM: a frame is only accepted from IDLE; otherwise it is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) frame_buf[k] <= '0;
    end else begin
      if (frame_done_c && (state == SEND)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_done_c) begin
            for (int k = 0; k < NUM_CH; k++) frame_buf[k] <= avg_c[k];
            out_ch    <= '0;
            out_data  <= avg_c[0];
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_ch_c) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              out_ch   <= next_ch_c;
              out_data <= frame_buf[next_ch_c];
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Self-checking bench for adc_sampler: scoreboard on the output stream, a table
// of averaging vectors, and hand-written multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_adc_sampler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic [15:0] sample_div;
  logic [15:0] ch_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [7:0]  out_data;
  logic        overrun;
  logic        clr_overrun;

  logic        f_enable;
  logic [15:0] f_div;
  logic [7:0]  f_data;
  logic        f_valid;
  logic        f_ready;
  logic [0:0]  f_ch;
  logic [7:0]  f_out;
  logic        f_ovr;
  logic        f_clr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [0:0] ch;
    logic [7:0] data;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    logic [3:0][7:0] c0;
    logic [3:0][7:0] c1;
    logic [7:0]      e0;
    logic [7:0]      e1;
  } vec_t;
  vec_t vecs[6];

  adc_sampler u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sample_div (sample_div),
    .ch_data    (ch_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  adc_sampler #(.NUM_CH(1), .DATA_W(8), .AVG_LOG2(0), .DIV_W(16)) u_fast (
    .clk        (clk),
    .rst        (rst),
    .enable     (f_enable),
    .sample_div (f_div),
    .ch_data    (f_data),
    .out_valid  (f_valid),
    .out_ready  (f_ready),
    .out_ch     (f_ch),
    .out_data   (f_out),
    .overrun    (f_ovr),
    .clr_overrun(f_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [0:0] ch, input logic [7:0] data);
    word_t w;
    w.ch   = ch;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake pops and compares one expected word
  always @(negedge clk) begin
    word_t w;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=ch%0d/0x%0h required=none", out_ch, out_data);
      end else begin
        w = exp_q.pop_front();
        chk("sb_ch", 32'(out_ch), 32'(w.ch));
        chk("sb_data", 32'(out_data), 32'(w.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{c0: {8'h40, 8'h40, 8'h40, 8'h40}, c1: {8'h80, 8'h80, 8'h80, 8'h80}, e0: 8'h40, e1: 8'h80};
    vecs[1] = '{c0: {8'h04, 8'h03, 8'h02, 8'h01}, c1: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, e0: 8'h02, e1: 8'hFF};
    vecs[2] = '{c0: {8'h00, 8'h00, 8'h00, 8'h00}, c1: {8'h03, 8'h00, 8'h00, 8'h00}, e0: 8'h00, e1: 8'h00};
    vecs[3] = '{c0: {8'hFE, 8'hFF, 8'hFF, 8'hFF}, c1: {8'h41, 8'h30, 8'h20, 8'h10}, e0: 8'hFE, e1: 8'h28};
    vecs[4] = '{c0: {8'h00, 8'h01, 8'h01, 8'h01}, c1: {8'h80, 8'h7F, 8'h80, 8'h7F}, e0: 8'h00, e1: 8'h7F};
    vecs[5] = '{c0: {8'h03, 8'h03, 8'h03, 8'h03}, c1: {8'hC3, 8'hC2, 8'hC1, 8'hC0}, e0: 8'h03, e1: 8'hC1};

    rst = 1'b0; enable = 1'b0; sample_div = '0; ch_data = '0; out_ready = 1'b0; clr_overrun = 1'b0;
    f_enable = 1'b0; f_div = '0; f_data = '0; f_ready = 1'b0; f_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fast_valid", 32'(f_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Constant inputs, sample_div=3: first word after 16 edges, then every 16
    sample_div = 16'd3; ch_data = {8'h80, 8'h40}; out_ready = 1'b1; enable = 1'b1;
    repeat (3) begin push(1'b0, 8'h40); push(1'b1, 8'h80); end
    for (int e = 1; e <= 48; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 15) chk("lat_before", 32'(out_valid), 32'd0);
      if (e == 16) chk("lat_rise", 32'(out_valid), 32'd1);
      if (e == 17) chk("word1_ch", 32'(out_ch), 32'd1);
      if (e == 18) chk("drain_fall", 32'(out_valid), 32'd0);
      if (e == 31) chk("period_before", 32'(out_valid), 32'd0);
      if (e == 32) chk("period_rise", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    enable = 1'b0;
    drain("const_drain");
    chk("const_overrun", 32'(overrun), 32'd0);

    // Backpressure: first frame held, second dropped with overrun
    rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
    sample_div = 16'd3; ch_data = {8'h80, 8'h40}; out_ready = 1'b0; enable = 1'b1;
    push(1'b0, 8'h40); push(1'b1, 8'h80);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 16) ch_data = {8'h22, 8'h11};
      if (e == 20) begin
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ch", 32'(out_ch), 32'd0);
        chk("bp_data", 32'(out_data), 32'h40);
      end
      if (e == 31) chk("bp_ovr_before", 32'(overrun), 32'd0);
      if (e == 32) chk("bp_ovr_set", 32'(overrun), 32'd1);
      if (e == 40) begin
        chk("bp_hold_ch", 32'(out_ch), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'h40);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1; enable = 1'b0;
    drain("bp_drain");
    chk("bp_ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("bp_ovr_clear", 32'(overrun), 32'd0);
    @(posedge clk); #1;

    // Table of averaging vectors, one tick per cycle
    sample_div = 16'd0; out_ready = 1'b1;
    foreach (vecs[r]) begin
      push(1'b0, vecs[r].e0); push(1'b1, vecs[r].e1);
      for (int i = 0; i < 4; i++) begin
        ch_data = {vecs[r].c1[i], vecs[r].c0[i]};
        enable  = 1'b1;
        @(posedge clk); #1;
      end
    end
    enable = 1'b0;
    drain("vec_drain");
    chk("vec_overrun", 32'(overrun), 32'd0);

    // Enable drop: partial frame discarded, pending SEND still drains
    out_ready = 1'b0; ch_data = {8'h33, 8'h33}; enable = 1'b1;
    push(1'b0, 8'h33); push(1'b1, 8'h33);
    repeat (4) @(posedge clk);
    #1;
    ch_data = {8'hF0, 8'hF0};
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    chk("en_hold_valid", 32'(out_valid), 32'd1);
    chk("en_hold_data", 32'(out_data), 32'h33);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("en_send_drain");
    push(1'b0, 8'h10); push(1'b1, 8'h10);
    ch_data = {8'h10, 8'h10}; enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    drain("en_fresh_drain");
    chk("en_overrun", 32'(overrun), 32'd0);

    // Reset asserted mid-SEND on the second word
    ch_data = {8'h66, 8'h55}; out_ready = 1'b1; enable = 1'b1;
    push(1'b0, 8'h55);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rs_pre_valid", 32'(out_valid), 32'd1);
    chk("rs_pre_ch", 32'(out_ch), 32'd1);
    chk("rs_pre_data", 32'(out_data), 32'h66);
    #2; rst = 1'b0; #1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_ch", 32'(out_ch), 32'd0);
    chk("rs_data", 32'(out_data), 32'd0);
    chk("rs_overrun", 32'(overrun), 32'd0);
    chk("rs_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    push(1'b0, 8'h55); push(1'b1, 8'h66);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 3) chk("rs_lat_before", 32'(out_valid), 32'd0);
      if (e == 4) begin
        chk("rs_lat_rise", 32'(out_valid), 32'd1);
        chk("rs_first_ch", 32'(out_ch), 32'd0);
      end
    end
    @(posedge clk); #1;
    enable = 1'b0;
    drain("rs_drain");

    // Fastest rate, single channel, no averaging: every other sample dropped
    f_div = 16'd0; f_ready = 1'b1; f_data = 8'd0; f_enable = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      f_data = 8'(e);
      @(negedge clk);
      if (e % 2 == 1) begin
        chk($sformatf("fast_valid_%0d", e), 32'(f_valid), 32'd1);
        chk($sformatf("fast_data_%0d", e), 32'(f_out), 32'(e - 1));
      end else begin
        chk($sformatf("fast_valid_%0d", e), 32'(f_valid), 32'd0);
      end
      if (e == 1) chk("fast_ovr_before", 32'(f_ovr), 32'd0);
      if (e == 2) chk("fast_ovr_set", 32'(f_ovr), 32'd1);
    end
    f_enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
